rr_stream_arbiter: RTL

RR_STREAM_ARBITER -- requirements
Module: rr_stream_arbiter

---
 rtl/rr_stream_arbiter_pkg.sv | 7 +
 rtl/rr_priority_pick.sv | 25 ++
 rtl/rr_stream_arbiter.sv | 85 ++++++++
 3 files changed

// File: rtl/rr_stream_arbiter_pkg.sv
// Shared stream definitions used by the source, buffer, sink and arbiter blocks.
package rr_stream_arbiter_pkg;

    localparam int STREAM_DATA_WIDTH = 8;
    localparam int COUNT_WIDTH       = 16;

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating-priority search: first set request at or after (last+1), wrapping around.
module rr_priority_pick #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] last,
    output logic [ID_WIDTH-1:0] grant,
    output logic                any_req
);

    int idx_s;

    // Scan from the farthest offset down to last+1 so the nearest set request wins.
    always_comb begin
        grant   = {ID_WIDTH{1'b0}};
        any_req = |req;
        idx_s   = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx_s = (int'(last) + k) % NUM_REQ;
            grant = req[idx_s] ? ID_WIDTH'(idx_s) : grant;
        end
    end

endmodule

// File: rtl/rr_stream_arbiter.sv
// Round-robin N:1 stream arbiter with a single registered output stage.
module rr_stream_arbiter
    import rr_stream_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = STREAM_DATA_WIDTH,
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_REQ-1:0]            in_valid,
    output logic [NUM_REQ-1:0]            in_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ID_WIDTH-1:0]           out_id,
    output logic [COUNT_WIDTH-1:0]        beat_count
);

    logic [ID_WIDTH-1:0]    last_grant_r;
    logic [ID_WIDTH-1:0]    pick_grant_s;
    logic                   any_req_s;
    logic                   load_en_s;
    logic                   transfer_s;
    logic [NUM_REQ-1:0]     in_ready_s;
    logic [DATA_WIDTH-1:0]  out_data_r;
    logic                   out_valid_r;
    logic [ID_WIDTH-1:0]    out_id_r;
    logic [COUNT_WIDTH-1:0] beat_count_r;

    rr_priority_pick #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_pick (
        .req     (in_valid),
        .last    (last_grant_r),
        .grant   (pick_grant_s),
        .any_req (any_req_s)
    );

    assign load_en_s  = !out_valid_r || out_ready;
    // Reset gating keeps every ready low while rst is held, even with requests pending.
    assign transfer_s = load_en_s && any_req_s && !rst;

    // One-hot ready toward the granted requester only.
    always_comb begin
        in_ready_s = {NUM_REQ{1'b0}};
        if (transfer_s) begin
            in_ready_s[pick_grant_s] = 1'b1;
        end else begin
            in_ready_s = {NUM_REQ{1'b0}};
        end
    end

    // Output register, fairness pointer and delivered-beat counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_r   <= {DATA_WIDTH{1'b0}};
            out_valid_r  <= 1'b0;
            out_id_r     <= {ID_WIDTH{1'b0}};
            last_grant_r <= ID_WIDTH'(NUM_REQ - 1);
            beat_count_r <= {COUNT_WIDTH{1'b0}};
        end else begin
            if (transfer_s) begin
                out_data_r   <= in_data[int'(pick_grant_s)*DATA_WIDTH +: DATA_WIDTH];
                out_id_r     <= pick_grant_s;
                out_valid_r  <= 1'b1;
                last_grant_r <= pick_grant_s;
            end else if (out_ready) begin
                out_valid_r  <= 1'b0;
            end
            if (out_valid_r && out_ready) begin
                beat_count_r <= beat_count_r + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    assign in_ready   = in_ready_s;
    assign out_data   = out_data_r;
    assign out_valid  = out_valid_r;
    assign out_id     = out_id_r;
    assign beat_count = beat_count_r;

endmodule
